// File: rtl/trace_packer_pkg.sv
// trace_packer_pkg: shared constants, header helpers and FSM state type for
// the trace packer. When TRACE_PACKER_TIMESTAMP_EN is defined the state type
// gains the TSTAMP state.
package trace_packer_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         HDR_SYNC_LSB = 24;
  localparam int         HDR_LEN_LSB  = 16;
  localparam int         HDR_OVF_BIT  = 15;
  localparam int         SEQ_BITS     = 15;

  // Number of 32-bit words needed to carry 'bits' bits.
  function automatic int words_for_bits(input int bits);
    return (bits + 31) / 32;
  endfunction

  // Header layout: sync byte, word count, overflow flag, sequence number.
  function automatic logic [31:0] make_header(input logic [7:0]          len,
                                              input logic                ovf,
                                              input logic [SEQ_BITS-1:0] seq);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_SYNC_LSB +: 8]     = SYNC_BYTE;
    hdr[HDR_LEN_LSB +: 8]      = len;
    hdr[HDR_OVF_BIT]           = ovf;
    hdr[SEQ_BITS-1:0]          = seq;
    return hdr;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
`ifdef TRACE_PACKER_TIMESTAMP_EN
    , ST_TSTAMP = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/record_fifo.sv
// record_fifo: first-word-fall-through FIFO of whole trace records.
//   clk, rst      : clock, asynchronous active-high reset (pointers only)
//   i_push/i_data : write one entry (ignored when full)
//   i_pop         : discard head entry (ignored when empty)
//   o_head        : current head entry, valid whenever !o_empty
//   o_full/o_empty/o_level : occupancy status
module record_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign o_level   = w_level;
  assign o_full    = (w_level == (AW+1)'(DEPTH));
  assign o_empty   = (w_level == '0);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trace_packer.sv
// trace_packer: captures trace records into a FIFO and serialises each as a
// header word plus 32-bit payload words (LSW first) on a valid/ready stream.
// Never stalls the producer; records arriving while full are dropped/counted.
//   clk, rst       : clock, asynchronous active-high reset
//   counter        : free-running cycle count (timestamp source)
//   wb_data_ready  : capture strobe for wb_data_i
//   m_data/m_valid/m_ready/m_last : output word stream
//   drop_count     : saturating count of dropped records
//   fifo_level     : records queued (excluding the one being sent)
//   busy           : FIFO non-empty or a record in flight
// Optional: define TRACE_PACKER_TIMESTAMP_EN to store the capture-time counter
// with each record and emit it as one word after the header.
module trace_packer
  import trace_packer_pkg::*;
#(
  parameter int  FIFO_DEPTH   = 8,
  parameter type trace_format = logic [79:0]
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   counter,
  input  logic                          wb_data_ready,
  input  trace_format                   wb_data_i,
  output logic [31:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  localparam int REC_BITS = $bits(trace_format);
  localparam int N_WORDS  = words_for_bits(REC_BITS);
  localparam logic [7:0] LAST_IDX = 8'(N_WORDS - 1);
`ifdef TRACE_PACKER_TIMESTAMP_EN
  localparam int ENTRY_BITS = REC_BITS + 32;
  localparam int HDR_LEN    = N_WORDS + 1;
`else
  localparam int ENTRY_BITS = REC_BITS;
  localparam int HDR_LEN    = N_WORDS;
`endif

  logic [REC_BITS-1:0]   w_rec;
  logic [ENTRY_BITS-1:0] w_entry;
  logic [ENTRY_BITS-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [N_WORDS*32-1:0] w_pad;
  logic [31:0]           w_next_word;

  state_t                r_state, state_next;
  logic [31:0]           r_m_data, m_data_next;
  logic                  r_m_valid, m_valid_next;
  logic                  r_m_last, m_last_next;
  logic [SEQ_BITS-1:0]   r_seq, seq_next;
  logic                  r_ovf, ovf_next;
  logic [ENTRY_BITS-1:0] r_hold, hold_next;
  logic [7:0]            r_idx, idx_next;
  logic [15:0]           r_drop_count;

  assign w_rec = wb_data_i;
`ifdef TRACE_PACKER_TIMESTAMP_EN
  assign w_entry = {counter, w_rec};
`else
  logic w_unused_counter;
  assign w_unused_counter = ^counter;
  assign w_entry = w_rec;
`endif

  // Full is the pre-edge state, so a same-edge pop never rescues a push.
  assign w_push = wb_data_ready && !w_full;
  assign w_drop = wb_data_ready && w_full;

  record_fifo #(.WIDTH(ENTRY_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Zero-extend the record so the last payload word is padded with zeros.
  assign w_pad       = (N_WORDS*32)'(r_hold[REC_BITS-1:0]);
  assign w_next_word = w_pad[32*(int'(r_idx) + 1) +: 32];

  always_comb begin
    state_next   = r_state;
    m_data_next  = r_m_data;
    m_valid_next = r_m_valid;
    m_last_next  = r_m_last;
    seq_next     = r_seq;
    ovf_next     = r_ovf;
    hold_next    = r_hold;
    idx_next     = r_idx;
    w_pop        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_pop = 1'b1;
      end
      ST_HEADER: begin
        if (m_ready) begin
          seq_next = r_seq + 1'b1;
`ifdef TRACE_PACKER_TIMESTAMP_EN
          m_data_next = r_hold[ENTRY_BITS-1 -: 32];
          state_next  = ST_TSTAMP;
`else
          m_data_next = w_pad[31:0];
          m_last_next = (LAST_IDX == 8'd0);
          idx_next    = 8'd0;
          state_next  = ST_PAYLOAD;
`endif
        end
      end
`ifdef TRACE_PACKER_TIMESTAMP_EN
      ST_TSTAMP: begin
        if (m_ready) begin
          m_data_next = w_pad[31:0];
          m_last_next = (LAST_IDX == 8'd0);
          idx_next    = 8'd0;
          state_next  = ST_PAYLOAD;
        end
      end
`endif
      ST_PAYLOAD: begin
        if (m_ready) begin
          if (r_idx == LAST_IDX) begin
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              m_valid_next = 1'b0;
              m_last_next  = 1'b0;
              state_next   = ST_IDLE;
            end
          end else begin
            idx_next    = r_idx + 8'd1;
            m_data_next = w_next_word;
            m_last_next = (r_idx + 8'd1 == LAST_IDX);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Starting a record: latch the head and present its header at once.
    if (w_pop) begin
      hold_next    = w_head;
      m_data_next  = make_header(8'(HDR_LEN), r_ovf, r_seq);
      m_valid_next = 1'b1;
      m_last_next  = 1'b0;
      ovf_next     = 1'b0;
      state_next   = ST_HEADER;
    end
    // A drop on the same edge re-arms the flag for the following header.
    if (w_drop) ovf_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_seq        <= '0;
      r_ovf        <= 1'b0;
      r_hold       <= '0;
      r_idx        <= '0;
      r_drop_count <= '0;
    end else begin
      r_state   <= state_next;
      r_m_data  <= m_data_next;
      r_m_valid <= m_valid_next;
      r_m_last  <= m_last_next;
      r_seq     <= seq_next;
      r_ovf     <= ovf_next;
      r_hold    <= hold_next;
      r_idx     <= idx_next;
      if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign drop_count = r_drop_count;
  assign busy       = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_trace_packer.sv
module tb_trace_packer;
  localparam int DEPTH = 4;
  localparam int RB    = 80;
  localparam int NW    = (RB + 31) / 32;
`ifdef TRACE_PACKER_TIMESTAMP_EN
  localparam int TSW = 1;
`else
  localparam int TSW = 0;
`endif
  localparam int LEN = NW + TSW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   counter = '0;
  logic          wb_data_ready = 1'b0;
  logic [RB-1:0] wb_data_i = '0;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [15:0]   drop_count;
  logic [2:0]    fifo_level;
  logic          busy;

  trace_packer #(.FIFO_DEPTH(DEPTH), .trace_format(logic [79:0])) dut (
    .clk           (clk),
    .rst           (rst),
    .counter       (counter),
    .wb_data_ready (wb_data_ready),
    .wb_data_i     (wb_data_i),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .drop_count    (drop_count),
    .fifo_level    (fifo_level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting records, the word count left in the
  // record being sent, and the expected word stream.
  typedef struct { logic [31:0] d; logic last; } word_t;
  word_t         sb[$];
  logic [RB-1:0] q_rec[$];
  logic [31:0]   q_ts[$];
  bit            md_active = 0;
  int            md_left   = 0;
  bit            md_ovf    = 0;
  int            md_seq    = 0;
  int            md_drops  = 0;
  int            cyc       = 0;

  task automatic model_reset();
    sb.delete(); q_rec.delete(); q_ts.delete();
    md_active = 0; md_left = 0; md_ovf = 0; md_seq = 0; md_drops = 0;
  endtask

  task automatic model_start();
    logic [RB-1:0]    rec;
    logic [31:0]      ts;
    logic [NW*32-1:0] pad;
    word_t            w;
    rec = q_rec.pop_front();
    ts  = q_ts.pop_front();
    pad = '0;
    pad[RB-1:0] = rec;
    w.d = {8'hA5, 8'(LEN), md_ovf, 15'(md_seq)};
    w.last = 1'b0;
    sb.push_back(w);
    md_ovf = 0;
    md_seq = (md_seq + 1) % 32768;
    if (TSW == 1) begin
      w.d = ts; w.last = 1'b0; sb.push_back(w);
    end
    for (int k = 0; k < NW; k++) begin
      w.d = pad[32*k +: 32];
      w.last = (k == NW - 1);
      sb.push_back(w);
    end
    md_left   = 1 + TSW + NW;
    md_active = 1;
  endtask

  task automatic model_step(input bit stb, input logic [RB-1:0] rec, input bit rdy, input logic [31:0] ts);
    bit full;
    full = (q_rec.size() == DEPTH);
    if (!md_active) begin
      if (q_rec.size() > 0) model_start();
    end else if (rdy) begin
      md_left--;
      if (md_left == 0) begin
        if (q_rec.size() > 0) model_start();
        else md_active = 0;
      end
    end
    if (stb) begin
      if (full) begin
        if (md_drops < 65535) md_drops++;
        md_ovf = 1;
      end else begin
        q_rec.push_back(rec);
        q_ts.push_back(ts);
      end
    end
  endtask

  task automatic cycle(input bit stb, input logic [RB-1:0] rec, input bit rdy);
    wb_data_ready = stb;
    wb_data_i     = rec;
    m_ready       = rdy;
    counter       = 32'(cyc);
    @(posedge clk);
    model_step(stb, rec, rdy, 32'(cyc));
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_data_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every transferred word against the scoreboard, checks
  // that stalled words hold, and tracks the status outputs every cycle.
  bit          stall_pend = 0;
  logic [31:0] stall_d;
  logic        stall_l;
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 0;
    end else begin
      chk("m_valid", 32'(m_valid), 32'(md_active));
      chk("fifo_level", 32'(fifo_level), 32'(q_rec.size()));
      chk("drop_count", 32'(drop_count), 32'(md_drops));
      chk("busy", 32'(busy), 32'(md_active || q_rec.size() > 0));
      if (stall_pend) begin
        chk("stall_data", m_data, stall_d);
        chk("stall_last", 32'(m_last), 32'(stall_l));
      end
      if (m_valid && m_ready) begin
        stall_pend = 0;
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(sb.size()), 32'd1);
        end else begin
          word_t w;
          w = sb.pop_front();
          chk("word_data", m_data, w.d);
          chk("word_last", 32'(m_last), 32'(w.last));
        end
      end else if (m_valid) begin
        stall_pend = 1; stall_d = m_data; stall_l = m_last;
      end else begin
        stall_pend = 0;
      end
    end
  end

  localparam logic [79:0] REC0 = 80'h1234_89ABCDEF_01234567;

  initial begin
    logic [RB-1:0] r;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_last", 32'(m_last), 32'h0);

    // Single record, sink always ready.
    cycle(1, REC0, 1);
    repeat (8) cycle(0, '0, 1);

    // Same record with a toggling sink.
    cycle(1, REC0, 1);
    for (int i = 0; i < 14; i++) cycle(0, '0, (i % 2) == 0);
    repeat (4) cycle(0, '0, 1);

    // Overflow: one record enters the FSM, four queue, two drop.
    for (int i = 0; i < 7; i++) cycle(1, 80'(i + 16), 0);
    repeat (2) cycle(0, '0, 0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_drops", 32'(drop_count), 32'd2);
    repeat (30) cycle(0, '0, 1);

    // Back-to-back records with no bubble.
    for (int i = 0; i < 3; i++) cycle(1, {16'h0BB0, 32'hC0DE0000 + 32'(i), 32'(i)}, 0);
    repeat (14) cycle(0, '0, 1);

    // Reset in the middle of a payload, then a fresh record.
    cycle(1, REC0, 1);
    repeat (4) cycle(0, '0, 1);
    do_reset();
    chk("mid_rst_valid", 32'(m_valid), 32'h0);
    chk("mid_rst_drops", 32'(drop_count), 32'h0);
    cycle(1, 80'hFACE_DEADBEEF_CAFEF00D, 1);
    repeat (8) cycle(0, '0, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      r = {16'($urandom), $urandom, $urandom};
      cycle(($urandom_range(0, 3) == 0), r, ($urandom_range(0, 9) < 7));
    end
    repeat (60) cycle(0, '0, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
